lfsr_engine: RTL and testbench
==============================

# lfsr_engine

Parametrised linear-feedback shift register with run-time taps, Fibonacci or Galois structure, seed loading, step enable, automatic lock-up recovery and on-line period measurement. It generates pseudo-random sequences for test-pattern, scrambler and noise sources in the design. It also self-reports the sequence period so software can confirm a tap set is maximal-length.

## Interface
- `WIDTH`, 16: register width in bits, minimum 2.
- `INIT`, 1: reset and recovery state; must be nonzero, and the design must fail elaboration if `INIT` is 0.
- `MODE`, 0: structure; 0 selects Fibonacci, 1 selects Galois.

Clocking: one clock; reset is synchronous and active-high.
- `clk`  input  1  clock; all state changes on its rising edge.
- `rst`  input  1  synchronous active-high reset.
- `en`  input  1  advance the register one step this cycle.
- `load`  input  1  load `seed` this cycle.
- `seed`  input  WIDTH  value captured on `load`.
- `taps`  input  WIDTH  feedback polynomial mask, sampled every step.
- `result`  output  WIDTH  current register state, registered.
- `lockup`  output  1  one-cycle pulse: all-zero state was prevented and `INIT` was substituted.
- `period`  output  WIDTH  last measured period, in steps.
- `period_valid`  output  1  sticky; `period` holds a valid measurement.
- `period_done`  output  1  one-cycle pulse when a measurement completes.

## Operation
- Fibonacci (`MODE`=0): fb = XOR-reduce(state & taps); next = {state[WIDTH-2:0], fb}.
- Galois (`MODE`=1): sh = {state[WIDTH-2:0], 0}; next = state[WIDTH-1] ? sh ^ taps : sh.
- Internal registers:
  - `ref`: start point of the current measurement.
  - `cnt`: steps taken since `ref`, WIDTH bits, saturating at all-ones.
- "Restart" means: `ref` <= new state, `cnt` <= 0, `period_valid` <= 0.
- Priority per cycle is rst > load > en step. With none of them asserted, all state holds.
- `rst`:
  - state <= `INIT` and restart.
  - `period` <= 0; `lockup` and `period_done` <= 0.
- `load` with nonzero `seed`: state <= `seed`; restart.
- `load` with `seed` = 0: state <= `INIT`; `lockup` pulses; restart.
- `en` step where next ≠ 0: state <= next.
  - If `cnt` is not saturated, `cnt` <= `cnt`+1.
  - If next == `ref` and `cnt` is not saturated:
    - `period` <= `cnt`+1 and `period_valid` <= 1.
    - `period_done` pulses.
    - `cnt` <= 0, so measurement continues and repeats every period.
- `en` step where next == 0 (lock-up, reachable with degenerate taps):
  - state <= `INIT`; `lockup` pulses; restart.
  - `period_done` is not asserted.
- Saturation: once `cnt` reaches all-ones it stays there.
  - No further measurement completes until a restart.
  - `period_valid` keeps its previous value.
- `taps` changes mid-run: the new taps apply from the next step. The measurement is not restarted; software reloads to measure cleanly.

## Timing
- Reset values:
  - `result` = `INIT`, `period` = 0.
  - `period_valid` = 0, `lockup` = 0, `period_done` = 0.
- Step latency is 1 cycle: `en` sampled high at edge k means `result` shows the new state after edge k.
- `period_done` and the updated `period` appear on the same edge at which `result` returns to `ref`.
- `lockup` is high for exactly the cycle after the substituting edge, then returns to 0 unless re-triggered.
- `load` and `en` asserted together: load wins; no step occurs that cycle.
- `rst` asserted mid-sequence: it overrides everything on that edge, with no residual pulses.
- Continuous `en` produces one new state per cycle, with no bubbles.

## Test plan
- Max-length sequence: WIDTH=4, MODE=0, taps=4'b1001, reset, then `en` held high.
  - `result` must follow 0011, 0111, 1111, 1110, 1101, 1010, 0101, 1011, 0110, 1100, 1001, 0010, 0100, 1000, 0001.
  - `period_done` pulses on the 15th step with `period`=15 and `period_valid`=1.
  - `period_done` pulses again 15 steps later.
- Seed load: WIDTH=4, MODE=0, taps=4'b1001, load seed=4'b1010 with `en`=1 in the same cycle.
  - `result`=1010 with no step that cycle.
  - `period_valid` clears to 0.
  - The next steps give 0101, then 1011.
  - `period`=15 after 15 steps.
- Zero seed: load seed=0.
  - `result`=`INIT`, `lockup` pulses for one cycle, `period_valid`=0.
- Lock-up recovery: WIDTH=4, MODE=1, taps=0, from state 1000 with `en` asserted.
  - The computed next state is 0, so `result`=0001 (`INIT`) and `lockup` pulses.
  - `period_done` stays 0.
- Saturation: WIDTH=4, MODE=0, taps=4'b0000, seed 0001, `en` held high.
  - The sequence is 0010, 0100, 1000, then the lock-up step to 0001.
  - Check `cnt` never falsely completes a measurement.
  - Separately force a non-returning sequence for ≥15 steps and confirm no `period_done` until a reload.
- Reset mid-run: assert `rst` during the 7th step of the max-length run.
  - All outputs return to their reset values on that edge.
  - The sequence restarts from 0011.

Source files
------------

// File: rtl/lfsr_if.sv
// Bus bundle for lfsr_engine: step/load controls, seed and taps in;
// generated state, lock-up pulse and period measurement out.
//   master: drives en, load, seed, taps; observes results
//   slave : the engine side
interface lfsr_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] taps;
  logic [WIDTH-1:0] result;
  logic             lockup;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             period_done;

  modport master (
    output en, load, seed, taps,
    input  result, lockup, period, period_valid, period_done
  );

  modport slave (
    input  en, load, seed, taps,
    output result, lockup, period, period_valid, period_done
  );

endinterface

// File: rtl/lfsr_engine.sv
// LFSR with run-time taps, Fibonacci (MODE=0) or Galois (MODE=1) structure,
// seed load, all-zero lock-up recovery and on-line period measurement.
// Ports:
//   clk  - clock, all state changes on rising edge
//   rst  - synchronous active-high reset
//   bus  - lfsr_if slave: en, load, seed, taps in;
//          result, lockup, period, period_valid, period_done out (registered)
module lfsr_engine #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned INIT  = 1,
  parameter int unsigned MODE  = 0
) (
  input  logic   clk,
  input  logic   rst,
  lfsr_if.slave  bus
);

  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

  // Elaboration guards: a zero start state would be a fixed point.
  if (WIDTH < 2) begin : g_width_check
    $error("lfsr_engine: WIDTH must be at least 2");
  end
  if (INIT_V == '0) begin : g_init_check
    $error("lfsr_engine: INIT must be nonzero");
  end
  if (MODE > 1) begin : g_mode_check
    $error("lfsr_engine: MODE must be 0 or 1");
  end

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] period_q;
  logic             valid_q;
  logic             lockup_q;
  logic             done_q;

  logic [WIDTH-1:0] sh_c;
  logic [WIDTH-1:0] nxt_c;
  logic [WIDTH-1:0] cnt_inc_c;
  logic             cnt_sat_c;

  // Next-state function for the selected structure.
  always_comb begin
    sh_c = {state_q[WIDTH-2:0], 1'b0};
    if (MODE == 0) begin
      nxt_c = {state_q[WIDTH-2:0], ^(state_q & bus.taps)};
    end else begin
      nxt_c = state_q[WIDTH-1] ? (sh_c ^ bus.taps) : sh_c;
    end
    cnt_inc_c = cnt_q + WIDTH'(1);
    cnt_sat_c = (cnt_q == '1);
  end

  // State, measurement and pulse registers; priority rst > load > en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= INIT_V;
      ref_q    <= INIT_V;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      lockup_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      lockup_q <= 1'b0;
      done_q   <= 1'b0;
      if (bus.load) begin
        cnt_q   <= '0;
        valid_q <= 1'b0;
        if (bus.seed != '0) begin
          state_q <= bus.seed;
          ref_q   <= bus.seed;
        end else begin
          state_q  <= INIT_V;
          ref_q    <= INIT_V;
          lockup_q <= 1'b1;
        end
      end else if (bus.en) begin
        if (nxt_c == '0) begin
          // Degenerate taps drove us to zero: substitute INIT and restart.
          state_q  <= INIT_V;
          ref_q    <= INIT_V;
          cnt_q    <= '0;
          valid_q  <= 1'b0;
          lockup_q <= 1'b1;
        end else begin
          state_q <= nxt_c;
          // A saturated counter freezes: no completion until a restart.
          if (!cnt_sat_c) begin
            if (nxt_c == ref_q) begin
              period_q <= cnt_inc_c;
              valid_q  <= 1'b1;
              done_q   <= 1'b1;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_inc_c;
            end
          end
        end
      end
    end
  end

  assign bus.result       = state_q;
  assign bus.lockup       = lockup_q;
  assign bus.period       = period_q;
  assign bus.period_valid = valid_q;
  assign bus.period_done  = done_q;

endmodule

// File: tb/tb_lfsr_engine.sv
// Bench for lfsr_engine: one Fibonacci and one Galois instance (WIDTH=4,
// INIT=1) driven side by side, a per-cycle reference model for both, and
// directed literal checks of the documented sequences.
module tb_lfsr_engine;

  localparam int unsigned W = 4;
  localparam int M = 1 << W;
  localparam int CMAX = M - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         load;
  logic [W-1:0] seed;
  logic [W-1:0] taps0;
  logic [W-1:0] taps1;

  int vectors = 0;
  int miscompares = 0;

  lfsr_if #(.WIDTH(W)) if0 ();
  lfsr_if #(.WIDTH(W)) if1 ();

  assign if0.en   = en;
  assign if0.load = load;
  assign if0.seed = seed;
  assign if0.taps = taps0;
  assign if1.en   = en;
  assign if1.load = load;
  assign if1.seed = seed;
  assign if1.taps = taps1;

  lfsr_engine #(.WIDTH(W), .INIT(1), .MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  lfsr_engine #(.WIDTH(W), .INIT(1), .MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  // Reference model: m_steps counts steps since the reference point.
  int m_state[2];
  int m_ref[2];
  int m_steps[2];
  int m_period[2];
  int m_pv[2];
  int m_lock[2];
  int m_done[2];
  bit seen_edge = 1'b0;

  function automatic int next_of(int s, int t, int mode);
    if (mode == 0) return ((s * 2) % M) + ($countones(s & t) % 2);
    return ((s * 2) % M) ^ ((s >= M / 2) ? t : 0);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int t;
      int n;
      t = (d == 0) ? int'(taps0) : int'(taps1);
      if (rst) begin
        m_state[d] = 1; m_ref[d] = 1; m_steps[d] = 0;
        m_period[d] = 0; m_pv[d] = 0; m_lock[d] = 0; m_done[d] = 0;
      end else begin
        m_lock[d] = 0;
        m_done[d] = 0;
        if (load) begin
          m_state[d] = (seed != 0) ? int'(seed) : 1;
          m_lock[d]  = (seed == 0) ? 1 : 0;
          m_ref[d]   = m_state[d];
          m_steps[d] = 0;
          m_pv[d]    = 0;
        end else if (en) begin
          n = next_of(m_state[d], t, d);
          if (n == 0) begin
            m_state[d] = 1; m_ref[d] = 1; m_steps[d] = 0; m_pv[d] = 0; m_lock[d] = 1;
          end else begin
            m_state[d] = n;
            if (m_steps[d] < CMAX) begin
              m_steps[d]++;
              if (n == m_ref[d]) begin
                m_period[d] = m_steps[d];
                m_pv[d] = 1;
                m_done[d] = 1;
                m_steps[d] = 0;
              end
            end
          end
        end
      end
    end
    seen_edge = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (seen_edge) begin
      check("m0.result", 32'(if0.result), m_state[0]);
      check("m0.lockup", 32'(if0.lockup), m_lock[0]);
      check("m0.period", 32'(if0.period), m_period[0]);
      check("m0.valid",  32'(if0.period_valid), m_pv[0]);
      check("m0.done",   32'(if0.period_done), m_done[0]);
      check("m1.result", 32'(if1.result), m_state[1]);
      check("m1.lockup", 32'(if1.lockup), m_lock[1]);
      check("m1.period", 32'(if1.period), m_period[1]);
      check("m1.valid",  32'(if1.period_valid), m_pv[1]);
      check("m1.done",   32'(if1.period_done), m_done[1]);
    end
  end

  // Apply inputs for one clock, return after the following negedge.
  task automatic step(input logic r, input logic l, input logic e, input logic [W-1:0] s);
    rst = r; load = l; en = e; seed = s;
    @(negedge clk);
  endtask

  task automatic check_reset0(input string tag);
    check({tag, ".result"}, 32'(if0.result), 1);
    check({tag, ".period"}, 32'(if0.period), 0);
    check({tag, ".valid"},  32'(if0.period_valid), 0);
    check({tag, ".lockup"}, 32'(if0.lockup), 0);
    check({tag, ".done"},   32'(if0.period_done), 0);
  endtask

  int exp_max[15] = '{3, 7, 15, 14, 13, 10, 5, 11, 6, 12, 9, 2, 4, 8, 1};

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; seed = '0;
    taps0 = 4'b1001; taps1 = 4'b1001;
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    check_reset0("rst");

    // Max-length run, two full periods.
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0, 1'b1, 4'd0);
      check("max.result", 32'(if0.result), exp_max[i]);
      check("max.done", 32'(if0.period_done), (i == 14) ? 1 : 0);
    end
    check("max.period", 32'(if0.period), 15);
    check("max.valid", 32'(if0.period_valid), 1);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0, 1'b1, 4'd0);
      check("max2.done", 32'(if0.period_done), (i == 14) ? 1 : 0);
    end

    // Seed load wins over en.
    step(1'b0, 1'b1, 1'b1, 4'b1010);
    check("seed.result", 32'(if0.result), 10);
    check("seed.valid", 32'(if0.period_valid), 0);
    step(1'b0, 1'b0, 1'b1, 4'd0);
    check("seed.s1", 32'(if0.result), 5);
    step(1'b0, 1'b0, 1'b1, 4'd0);
    check("seed.s2", 32'(if0.result), 11);
    for (int i = 0; i < 13; i++) step(1'b0, 1'b0, 1'b1, 4'd0);
    check("seed.done", 32'(if0.period_done), 1);
    check("seed.period", 32'(if0.period), 15);
    check("seed.back", 32'(if0.result), 10);

    // Zero seed substitutes INIT.
    step(1'b0, 1'b1, 1'b0, 4'd0);
    check("zero.result", 32'(if0.result), 1);
    check("zero.lockup", 32'(if0.lockup), 1);
    check("zero.valid", 32'(if0.period_valid), 0);
    step(1'b0, 1'b0, 1'b0, 4'd0);
    check("zero.lockup_end", 32'(if0.lockup), 0);

    // Galois lock-up recovery with zero taps.
    taps1 = 4'b0000;
    step(1'b0, 1'b1, 1'b0, 4'b1000);
    check("glk.seed", 32'(if1.result), 8);
    step(1'b0, 1'b0, 1'b1, 4'd0);
    check("glk.result", 32'(if1.result), 1);
    check("glk.lockup", 32'(if1.lockup), 1);
    check("glk.done", 32'(if1.period_done), 0);
    taps1 = 4'b1001;

    // Fibonacci zero taps: shift out then lock-up, repeatedly, never completing.
    taps0 = 4'b0000;
    step(1'b0, 1'b1, 1'b0, 4'b0001);
    step(1'b0, 1'b0, 1'b1, 4'd0); check("sat.s1", 32'(if0.result), 2);
    step(1'b0, 1'b0, 1'b1, 4'd0); check("sat.s2", 32'(if0.result), 4);
    step(1'b0, 1'b0, 1'b1, 4'd0); check("sat.s3", 32'(if0.result), 8);
    step(1'b0, 1'b0, 1'b1, 4'd0);
    check("sat.s4", 32'(if0.result), 1);
    check("sat.lockup", 32'(if0.lockup), 1);
    check("sat.done", 32'(if0.period_done), 0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 4'd0);
      check("sat.nodone", 32'(if0.period_done), 0);
    end

    // Non-returning trajectory 1110 -> {1101,1011,0110} cycle saturates cnt.
    taps0 = 4'b0011;
    step(1'b0, 1'b1, 1'b0, 4'b1110);
    step(1'b0, 1'b0, 1'b1, 4'd0); check("nr.s1", 32'(if0.result), 13);
    step(1'b0, 1'b0, 1'b1, 4'd0); check("nr.s2", 32'(if0.result), 11);
    step(1'b0, 1'b0, 1'b1, 4'd0); check("nr.s3", 32'(if0.result), 6);
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b0, 1'b1, 4'd0);
      check("nr.nodone", 32'(if0.period_done), 0);
    end
    // Switching to a maximal tap set revisits 1110, but saturation blocks it.
    taps0 = 4'b1001;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b1, 4'd0);
      check("satmax.nodone", 32'(if0.period_done), 0);
      check("satmax.valid", 32'(if0.period_valid), 0);
    end
    // Reload restarts measurement.
    step(1'b0, 1'b1, 1'b0, 4'b0001);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b1, 4'd0);
    check("reload.done", 32'(if0.period_done), 1);
    check("reload.period", 32'(if0.period), 15);

    // Reset on the 7th step of a running sequence.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 4'd0);
    check("mid.s6", 32'(if0.result), 10);
    step(1'b1, 1'b0, 1'b1, 4'd0);
    check_reset0("midrst");
    step(1'b0, 1'b0, 1'b1, 4'd0);
    check("mid.restart", 32'(if0.result), 3);
    step(1'b0, 1'b0, 1'b0, 4'd0);

    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
